// File: rtl/wb_write_arbiter.sv
// Register-file writer: merges ALU results and FIFO-buffered LSU loads into a
// single registered write port, with a starvation guard that lets the ALU win.
module wb_write_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  output logic                    alu_ready,
  input  logic                    lsu_valid,
  input  logic [4:0]              lsu_rd,
  input  logic [XLEN-1:0]         lsu_data,
  output logic                    lsu_ready,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [31:0]             busy_mask,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(STARVE_LIMIT + 2);

  logic [4:0]      r_rd_mem   [DEPTH];
  logic [XLEN-1:0] r_data_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [WW-1:0]   r_wait;

  logic            w_nonempty;
  logic            w_forced;
  logic            w_pop;
  logic            w_push;
  logic            w_alu_xfer;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic [31:0]     w_busy;

  always_comb begin
    w_nonempty  = (r_count != '0);
    w_forced    = (r_wait == WW'(STARVE_LIMIT));
    alu_ready   = !w_nonempty || w_forced;
    // A forced ALU win blocks the pop only when the ALU actually has a result.
    w_pop       = w_nonempty && !(w_forced && alu_valid);
    w_alu_xfer  = alu_valid && alu_ready;
    lsu_ready   = (r_count != CW'(DEPTH));
    w_push      = lsu_valid && lsu_ready;
    w_head_rd   = r_rd_mem[r_rptr];
    w_head_data = r_data_mem[r_rptr];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wptr]   <= lsu_rd;
      r_data_mem[r_wptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else if (alu_valid && !alu_ready) begin
      if (r_wait != WW'(STARVE_LIMIT)) r_wait <= r_wait + WW'(1);
    end else begin
      r_wait <= '0;
    end
  end

  // ALU transfer and FIFO pop are mutually exclusive; x0 items retire silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      if (w_alu_xfer) begin
        if (alu_rd != '0) begin
          rf_we    <= 1'b1;
          rf_waddr <= alu_rd;
          rf_wdata <= alu_data;
        end
      end else if (w_pop) begin
        if (w_head_rd != '0) begin
          rf_we    <= 1'b1;
          rf_waddr <= w_head_rd;
          rf_wdata <= w_head_data;
        end
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_busy[r_rd_mem[i]] = 1'b1;
    end
    if (rf_we) w_busy[rf_waddr] = 1'b1;
    w_busy[0] = 1'b0;
  end

  assign busy_mask  = w_busy;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based model of the writer.
module tb_wb_write_arbiter;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy_mask;
  logic [2:0]      fifo_count;

  wb_write_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } item_t;

  // Reference model: load queue, refusal streak, last write.
  item_t           fq[$];
  int              mwait;
  logic            m_we;
  logic [4:0]      m_waddr;
  logic [XLEN-1:0] m_wdata;
  bit              last_alu_acc;

  int nvec = 0;
  int nerr = 0;

  function automatic bit m_alu_ready();
    return (fq.size() == 0) || (mwait == LIMIT);
  endfunction

  function automatic bit m_lsu_ready();
    return fq.size() != DEPTH;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    foreach (fq[i]) if (fq[i].rd != 0) b[fq[i].rd] = 1'b1;
    if (m_we) b[m_waddr] = 1'b1;
    return b;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle 1ns.
  task automatic cycle(input bit r, input bit av, input logic [4:0] ard,
                       input logic [XLEN-1:0] ad, input bit lv,
                       input logic [4:0] lrd, input logic [XLEN-1:0] ld);
    bit ardy, lrdy, pop;
    item_t e;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    ardy = m_alu_ready();
    lrdy = m_lsu_ready();
    pop  = (fq.size() != 0) && !((mwait == LIMIT) && av);
    @(posedge clk);
    last_alu_acc = !r && av && ardy;
    if (r) begin
      fq.delete(); mwait = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      m_we = 0;
      if (av && ardy) begin
        if (ard != 0) begin m_we = 1; m_waddr = ard; m_wdata = ad; end
      end else if (pop) begin
        e = fq.pop_front();
        if (e.rd != 0) begin m_we = 1; m_waddr = e.rd; m_wdata = e.data; end
      end
      if (lv && lrdy) fq.push_back(item_t'{rd: lrd, data: ld});
      mwait = (av && !ardy) ? ((mwait < LIMIT) ? mwait + 1 : LIMIT) : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 5'd7, 64'h77, 1, 5'd8, 64'h88);
    cycle(1, 1, 5'd7, 64'h77, 1, 5'd8, 64'h88);
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    nvec++; if (busy_mask !== 32'h0) begin nerr++; $display("FAIL reset_busy got %h want 0", busy_mask); end
    nvec++; if (fifo_count !== 3'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    nvec++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL reset_lsu_ready got %0b want 1", lsu_ready); end
    nvec++; if (alu_ready !== 1'b1) begin nerr++; $display("FAIL reset_alu_ready got %0b want 1", alu_ready); end
    nvec++; if (rf_waddr !== 5'd0 || rf_wdata !== '0) begin
      nerr++; $display("FAIL reset_wregs got %0d/%h want 0/0", rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_alu_alone();
    cycle(0, 1, 5'd5, 64'h1234, 0, 5'd0, '0);
    nvec++; if (rf_we !== 1'b1) begin nerr++; $display("FAIL alu_we got %0b want 1", rf_we); end
    nvec++; if (rf_waddr !== 5'd5) begin nerr++; $display("FAIL alu_waddr got %0d want 5", rf_waddr); end
    nvec++; if (rf_wdata !== 64'h1234) begin nerr++; $display("FAIL alu_wdata got %h want 1234", rf_wdata); end
    nvec++; if (busy_mask !== 32'h20) begin nerr++; $display("FAIL alu_busy got %h want 00000020", busy_mask); end
    cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL alu_we_once got %0b want 0", rf_we); end
    nvec++; if (rf_wdata !== 64'h1234) begin nerr++; $display("FAIL alu_hold got %h want 1234", rf_wdata); end
    nvec++; if (busy_mask !== 32'h0) begin nerr++; $display("FAIL alu_busy_clr got %h want 0", busy_mask); end
  endtask

  task automatic test_lsu_fill_drain();
    bit exp_we;
    for (int k = 0; k < 7; k++) begin
      nvec++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL fd_lsu_ready k=%0d got %0b want 1", k, lsu_ready); end
      cycle(0, 0, 5'd0, '0, k < 5, 5'(k + 1), 64'hA000 + 64'(k + 1));
      exp_we = (k >= 1) && (k <= 5);
      nvec++; if (rf_we !== exp_we) begin nerr++; $display("FAIL fd_we k=%0d got %0b want %0b", k, rf_we, exp_we); end
      if (exp_we) begin
        nvec++; if (rf_waddr !== 5'(k) || rf_wdata !== 64'hA000 + 64'(k)) begin
          nerr++; $display("FAIL fd_write k=%0d got %0d/%h want %0d/%h", k, rf_waddr, rf_wdata, k, 64'hA000 + 64'(k));
        end
      end
    end
  endtask

  task automatic test_starve();
    int exp_rd [7] = '{0, 1, 2, 3, 10, 4, 5};
    bit exp_ardy [5] = '{0, 0, 0, 0, 1};
    for (int k = 0; k < 7; k++) begin
      if (k >= 1 && k <= 4) begin
        nvec++; if (alu_ready !== exp_ardy[k]) begin
          nerr++; $display("FAIL starve_ardy k=%0d got %0b want %0b", k, alu_ready, exp_ardy[k]);
        end
      end
      cycle(0, k >= 1 && k <= 4, 5'd10, 64'hBEEF, k <= 4, 5'(k + 1), 64'hB000 + 64'(k + 1));
      nvec++; if (rf_we !== (exp_rd[k] != 0)) begin
        nerr++; $display("FAIL starve_we k=%0d got %0b want %0b", k, rf_we, exp_rd[k] != 0);
      end
      if (exp_rd[k] != 0) begin
        nvec++; if (rf_waddr !== 5'(exp_rd[k]) || rf_wdata !== (exp_rd[k] == 10 ? 64'hBEEF : 64'hB000 + 64'(exp_rd[k]))) begin
          nerr++; $display("FAIL starve_write k=%0d got %0d/%h want rd %0d", k, rf_waddr, rf_wdata, exp_rd[k]);
        end
      end
    end
  endtask

  // Continuous ALU and LSU traffic until the FIFO reaches 'target' entries.
  task automatic fill_to(input int target, input string tag);
    logic [XLEN-1:0] ad = {$urandom, $urandom};
    int n = 0;
    while (fifo_count != 3'(target) && n < 60) begin
      cycle(0, 1, 5'd11, ad, 1, 5'($urandom_range(31, 1)), {$urandom, $urandom});
      if (last_alu_acc) ad = {$urandom, $urandom};
      nvec++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        nerr++; $display("FAIL %s_fill_write got %0b/%0d/%h want %0b/%0d/%h", tag, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
      n++;
    end
    if (n == 60) begin nvec++; nerr++; $display("FAIL %s_fill_timeout count %0d want %0d", tag, fifo_count, target); end
  endtask

  task automatic test_full_wrap();
    int n;
    for (int pass = 0; pass < 3; pass++) begin
      fill_to(4, "full");
      nvec++; if (fifo_count !== 3'd4) begin nerr++; $display("FAIL full_count got %0d want 4", fifo_count); end
      nvec++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL full_lsu_ready got %0b want 0", lsu_ready); end
      cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
      nvec++; if (fifo_count !== 3'd3) begin nerr++; $display("FAIL full_pop_count got %0d want 3", fifo_count); end
      nvec++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL full_pop_lsu_ready got %0b want 1", lsu_ready); end
      n = 0;
      while (fifo_count != 0 && n < 10) begin
        cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
        nvec++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
          nerr++; $display("FAIL wrap_drain got %0b/%0d/%h want %0b/%0d/%h", rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
        end
        n++;
      end
      nvec++; if (fifo_count !== 3'(fq.size())) begin
        nerr++; $display("FAIL wrap_empty got %0d want %0d", fifo_count, fq.size());
      end
      cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
    end
  endtask

  task automatic test_x0();
    logic [4:0] held = m_waddr;
    nvec++; if (alu_ready !== 1'b1) begin nerr++; $display("FAIL x0_alu_ready got %0b want 1", alu_ready); end
    cycle(0, 1, 5'd0, 64'hDEAD, 0, 5'd0, '0);
    nvec++; if (rf_we !== 1'b0 || busy_mask !== 32'h0) begin
      nerr++; $display("FAIL x0_alu got we %0b busy %h want 0/0", rf_we, busy_mask);
    end
    nvec++; if (rf_waddr !== held) begin nerr++; $display("FAIL x0_hold got %0d want %0d", rf_waddr, held); end
    cycle(0, 0, 5'd0, '0, 1, 5'd0, 64'hF00D);
    nvec++; if (fifo_count !== 3'd1 || busy_mask !== 32'h0) begin
      nerr++; $display("FAIL x0_push got count %0d busy %h want 1/0", fifo_count, busy_mask);
    end
    cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
    nvec++; if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
      nerr++; $display("FAIL x0_pop got count %0d we %0b want 0/0", fifo_count, rf_we);
    end
  endtask

  task automatic test_reset_mid();
    fill_to(3, "rmid");
    cycle(1, 1, 5'd12, 64'h12, 1, 5'd13, 64'h13);
    nvec++; if (fifo_count !== 3'd0 || busy_mask !== 32'h0 || rf_we !== 1'b0) begin
      nerr++; $display("FAIL rmid_reset got count %0d busy %h we %0b want 0/0/0", fifo_count, busy_mask, rf_we);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
      nvec++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
        nerr++; $display("FAIL rmid_after k=%0d got we %0b count %0d want 0/0", k, rf_we, fifo_count);
      end
    end
  endtask

  task automatic test_random();
    bit av = 0, lv = 0, r;
    logic [4:0] ard = '0, lrd = '0;
    logic [XLEN-1:0] ad = '0, ld = '0;
    bit lacc;
    for (int c = 0; c < 400; c++) begin
      if (!av) begin av = ($urandom % 2) == 0; ard = 5'($urandom); ad = {$urandom, $urandom}; end
      if (!lv) begin lv = ($urandom % 4) != 0; lrd = 5'($urandom); ld = {$urandom, $urandom}; end
      r = ($urandom % 64) == 0;
      lacc = !r && lv && m_lsu_ready();
      cycle(r, av, ard, ad, lv, lrd, ld);
      if (last_alu_acc) av = 0;
      if (lacc) lv = 0;
      nvec++; if (rf_we !== m_we) begin nerr++; $display("FAIL rnd_we c=%0d got %0b want %0b", c, rf_we, m_we); end
      nvec++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        nerr++; $display("FAIL rnd_wregs c=%0d got %0d/%h want %0d/%h", c, rf_waddr, rf_wdata, m_waddr, m_wdata);
      end
      nvec++; if (busy_mask !== m_busy()) begin nerr++; $display("FAIL rnd_busy c=%0d got %h want %h", c, busy_mask, m_busy()); end
      nvec++; if (fifo_count !== 3'(fq.size())) begin nerr++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, fifo_count, fq.size()); end
      nvec++; if (alu_ready !== m_alu_ready() || lsu_ready !== m_lsu_ready()) begin
        nerr++; $display("FAIL rnd_ready c=%0d got %0b/%0b want %0b/%0b", c, alu_ready, lsu_ready, m_alu_ready(), m_lsu_ready());
      end
    end
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    mwait = 0; m_we = 0; m_waddr = '0; m_wdata = '0; last_alu_acc = 0;
    test_reset();
    test_alu_alone();
    test_lsu_fill_drain();
    test_starve();
    test_full_wrap();
    test_x0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the integer register file: merges results from the ALU and the LSU into the file's single write port.
- Drives en_w/waddr/w_data as a registered write stream.
- Buffers LSU load results in a small FIFO.
- Arbitrates between ALU and LSU with a starvation guard.
- Exports a pending-destination mask so issue logic can stall on registers not yet written.

Parameters:
- XLEN, 64, data width of results and regfile write data.
- DEPTH, 4, LSU result FIFO entries; power of two, >= 2.
- STARVE_LIMIT, 3, consecutive cycles the ALU may be refused before it is forced to win.

Ports:
- clk  input  1  clock, posedge.
- rst  input  1  reset, synchronous, active-high.
- alu_valid  input  1  ALU result valid.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- alu_ready  output  1  ALU result accepted this cycle.
- lsu_valid  input  1  load result valid.
- lsu_rd  input  5  load destination register.
- lsu_data  input  XLEN  load data.
- lsu_ready  output  1  FIFO can accept a load result.
- rf_we  output  1  regfile write enable (en_w).
- rf_waddr  output  5  regfile write address.
- rf_wdata  output  XLEN  regfile write data.
- busy_mask  output  32  bit r set = write to xr pending inside this block.
- fifo_count  output  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: clears FIFO pointers/contents-valid, fifo_count=0, wait counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0. Asserting rst mid-operation drops all buffered and in-flight writes; no rf_we in the cycle after rst.
- Handshake: transfer when valid && ready on the same posedge. Producers hold rd/data stable while valid && !ready.
- LSU path:
  - lsu_ready = (fifo_count != DEPTH); it does not depend on lsu_valid.
  - Full FIFO: lsu_ready=0 even if a pop occurs that cycle (no same-cycle push-through when full).
  - Pushed entry is visible at the FIFO head the next cycle.
- Arbitration, evaluated each cycle with fifo_nonempty = fifo_count != 0:
  - FIFO empty: alu_ready=1.
  - FIFO non-empty and wait counter < STARVE_LIMIT: FIFO head pops; alu_ready=0.
  - FIFO non-empty and wait counter == STARVE_LIMIT: alu_ready=1; FIFO does not pop if alu_valid=1. If alu_valid=0, the FIFO pops.
  - Wait counter increments on each cycle with alu_valid && !alu_ready. It clears when the ALU transfers or alu_valid=0. It saturates at STARVE_LIMIT.
- Output register: the selected item (ALU transfer or FIFO pop) loads rf_waddr/rf_wdata the next posedge.
  - rf_we=1 for exactly that one cycle, otherwise 0.
  - rf_waddr/rf_wdata hold their last value when rf_we=0.
- Latency:
  - ALU transfer at edge N gives rf_we at cycle N+1.
  - LSU push at edge N into an empty FIFO, with no forced ALU win, gives rf_we at cycle N+2.
- x0:
  - Items with rd==0 complete their handshake and pop normally.
  - They never assert rf_we and never set busy_mask.
- Order:
  - FIFO entries retire in push order.
  - ALU and LSU results may retire out of order relative to each other. Issue logic guarantees no two in-flight writes to the same rd, so no WAW check exists here.
- busy_mask:
  - Combinational OR of one-hot(rd) over all valid FIFO entries and over the output register while rf_we=1.
  - bit 0 is always 0.
- Simultaneous LSU push and FIFO pop: fifo_count unchanged; pointers advance and wrap modulo DEPTH.
- Throughput: at most one regfile write per cycle; one push and one pop per cycle.

Test Plan:
- Reset: hold rst=1 two cycles with traffic -> rf_we=0, busy_mask=0, fifo_count=0, lsu_ready=1, alu_ready=1.
- ALU alone: alu_valid with rd=5, data=0x1234 at edge N -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 at cycle N+1 only; busy_mask[5]=1 during that cycle.
- LSU fill/drain: with DEPTH=4, 5 back-to-back loads rd=1..5 with ALU idle -> lsu_ready never drops.
  - Writes occur rd=1..5 in order, first at N+2, then one per cycle.
  - Same test with continuous alu_valid (rd=10) and STARVE_LIMIT=3 -> ALU refused 3 cycles, written on the 4th, then LSU resumes.
- Full FIFO: stall arbitration with continuous ALU forcing, push 4 loads -> fifo_count=4, lsu_ready=0.
  - Next pop: fifo_count=3, lsu_ready=1.
  - Pointer wrap-around verified over 3 full fill/drain cycles with data intact.
- x0 discard: ALU rd=0 and LSU rd=0 transfers -> handshakes complete, rf_we stays 0, busy_mask=0.
- Reset mid-operation: 3 entries buffered, assert rst one cycle -> no later rf_we for dropped entries, fifo_count=0, busy_mask=0.
